// File: rtl/slt_cmp_arbiter.sv
// Round-robin share of one set-less-than comparator between two request ports; 1-cycle latency.
// Backpressure: a port whose one-entry response buffer is full and not draining is not granted.
module slt_cmp_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req0_unsigned,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_result,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic                  req1_unsigned,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_result
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  is_unsigned;
  } cmp_req_t;

  // Opcode tagging is carried for the ALU family only; reject nonsensical widths at elaboration.
  if (OPCODE_LENGTH < 1 || DATA_WIDTH < 1) begin : g_param_check
    $error("slt_cmp_arbiter: DATA_WIDTH and OPCODE_LENGTH must be positive");
  end

  logic                  last_grant;
  logic                  elig0;
  logic                  elig1;
  logic                  grant0;
  logic                  grant1;
  cmp_req_t              cmp_req;
  logic [DATA_WIDTH-1:0] cmp_result;

  // last_grant == 1 means port 1 won last, so port 0 wins the next tie.
  always_comb begin
    elig0  = req0_valid && (!resp0_valid || resp0_ready);
    elig1  = req1_valid && (!resp1_valid || resp1_ready);
    grant0 = !reset && elig0 && (!elig1 || last_grant);
    grant1 = !reset && elig1 && (!elig0 || !last_grant);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    cmp_req = grant1 ? {req1_a, req1_b, req1_unsigned}
                     : {req0_a, req0_b, req0_unsigned};
  end

  always_comb begin
    cmp_result = '0;
    if (cmp_req.is_unsigned) begin
      cmp_result[0] = cmp_req.a < cmp_req.b;
    end else begin
      cmp_result[0] = $signed(cmp_req.a) < $signed(cmp_req.b);
    end
  end

  // A grant reloads the buffer even when it drains in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp0_valid  <= 1'b0;
      resp0_result <= '0;
      resp1_valid  <= 1'b0;
      resp1_result <= '0;
      last_grant   <= 1'b1;
    end else begin
      if (grant0) begin
        resp0_valid  <= 1'b1;
        resp0_result <= cmp_result;
      end else if (resp0_ready) begin
        resp0_valid  <= 1'b0;
      end
      if (grant1) begin
        resp1_valid  <= 1'b1;
        resp1_result <= cmp_result;
      end else if (resp1_ready) begin
        resp1_valid  <= 1'b0;
      end
      if (grant0 || grant1) begin
        last_grant <= grant1;
      end
    end
  end

endmodule

// File: tb/tb_slt_cmp_arbiter.sv
// Scoreboard bench for slt_cmp_arbiter: directed scenarios plus a negedge monitor checking every response.
module tb_slt_cmp_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_unsigned;
  logic [31:0] req0_a, req0_b;
  logic        resp0_valid, resp0_ready;
  logic [31:0] resp0_result;
  logic        req1_valid, req1_ready, req1_unsigned;
  logic [31:0] req1_a, req1_b;
  logic        resp1_valid, resp1_ready;
  logic [31:0] resp1_result;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  int          gnt_log[$];

  always #5 clk = ~clk;

  slt_cmp_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_unsigned(req0_unsigned), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_unsigned(req1_unsigned), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result)
  );

  // Signed order equals unsigned order once both sign bits are flipped.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic u);
    logic [31:0] x;
    logic [31:0] y;
    x = a;
    y = b;
    if (!u) begin
      x[31] = ~x[31];
      y[31] = ~y[31];
    end
    return (x < y) ? 32'd1 : 32'd0;
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_cmp++;
      if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
        n_fail++;
        $display("FAIL both_ready: req0_ready=%b req1_ready=%b, required at most one high", req0_ready, req1_ready);
      end
      if (req0_valid && req0_ready === 1'b1) begin
        exp0_q.push_back(model(req0_a, req0_b, req0_unsigned));
        gnt_log.push_back(0);
      end
      if (req1_valid && req1_ready === 1'b1) begin
        exp1_q.push_back(model(req1_a, req1_b, req1_unsigned));
        gnt_log.push_back(1);
      end
      if (resp0_valid === 1'b1 && resp0_ready) begin
        n_cmp++;
        if (exp0_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp0_spurious: result=%h with no request outstanding", resp0_result);
        end else begin
          logic [31:0] e0;
          e0 = exp0_q.pop_front();
          if (resp0_result !== e0) begin
            n_fail++;
            $display("FAIL resp0_result: got %h expected %h", resp0_result, e0);
          end
        end
      end
      if (resp1_valid === 1'b1 && resp1_ready) begin
        n_cmp++;
        if (exp1_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp1_spurious: result=%h with no request outstanding", resp1_result);
        end else begin
          logic [31:0] e1;
          e1 = exp1_q.pop_front();
          if (resp1_result !== e1) begin
            n_fail++;
            $display("FAIL resp1_result: got %h expected %h", resp1_result, e1);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one request and holds it until accepted; returns 1 cycle after the accepting edge.
  task automatic send(input int port, input logic [31:0] a, input logic [31:0] b, input logic u);
    logic ok;
    ok = 1'b0;
    if (port == 0) begin
      req0_a = a; req0_b = b; req0_unsigned = u; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_unsigned = u; req1_valid = 1'b1;
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (port == 0) ? (req0_ready === 1'b1) : (req1_ready === 1'b1);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: port %0d ready=0 for 20 cycles, required 1", port);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_unsigned = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_unsigned = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: req0_ready=%b req1_ready=%b, required 0/0", req0_ready, req1_ready);
    end
    n_cmp++;
    if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || resp0_result !== 32'd0 || resp1_result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_resp: valid=%b/%b result=%h/%h, required 0/0 0/0",
               resp0_valid, resp1_valid, resp0_result, resp1_result);
    end
    tick();
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_port0_signed;
    logic [31:0] av[3] = '{32'h5, 32'hF, 32'hA};
    logic [31:0] ex[3] = '{32'h1, 32'h0, 32'h0};
    resp0_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(0, av[k], 32'hA, 1'b0);
      n_cmp++;
      if (resp0_valid !== 1'b1 || resp0_result !== ex[k]) begin
        n_fail++;
        $display("FAIL port0_signed[%0d]: valid=%b result=%h, required 1 %h", k, resp0_valid, resp0_result, ex[k]);
      end
    end
    tick();
  endtask

  task automatic test_port1_mixed;
    logic [31:0] av[4] = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'h80000000, 32'h80000000};
    logic [31:0] bv[4] = '{32'h3, 32'h3, 32'h7FFFFFFF, 32'h7FFFFFFF};
    logic        uv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ex[4] = '{32'h1, 32'h0, 32'h1, 32'h0};
    resp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(1, av[k], bv[k], uv[k]);
      n_cmp++;
      if (resp1_valid !== 1'b1 || resp1_result !== ex[k]) begin
        n_fail++;
        $display("FAIL port1_cmp[%0d]: valid=%b result=%h, required 1 %h", k, resp1_valid, resp1_result, ex[k]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] a0[3] = '{32'h1, 32'hFFFFFFFF, 32'h9};
    logic [31:0] a1[3] = '{32'h80000000, 32'h2, 32'h7};
    int i0, i1;
    logic g0, g1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    gnt_log.delete();
    i0 = 0; i1 = 0;
    for (int c = 0; c < 6; c++) begin
      req0_valid = 1'b1; req0_a = a0[i0 % 3]; req0_b = 32'h3; req0_unsigned = 1'(c / 2 % 2);
      req1_valid = 1'b1; req1_a = a1[i1 % 3]; req1_b = 32'h5; req1_unsigned = 1'(c / 3);
      @(negedge clk);
      g0 = req0_ready;
      g1 = req1_ready;
      tick();
      if (g0 === 1'b1) i0++;
      if (g1 === 1'b1) i1++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++;
    if (gnt_log.size() != 6 || i0 != 3 || i1 != 3) begin
      n_fail++;
      $display("FAIL b2b_count: grants=%0d port0=%0d port1=%0d, required 6 3 3", gnt_log.size(), i0, i1);
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_cmp++;
        if (gnt_log[k] != k % 2) begin
          n_fail++;
          $display("FAIL b2b_order[%0d]: granted port %0d, required %0d", k, gnt_log[k], k % 2);
        end
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_backpressure;
    resp0_ready = 1'b0; resp1_ready = 1'b1;
    send(0, 32'h1, 32'h2, 1'b0);
    req0_valid = 1'b1; req0_a = 32'h7; req0_b = 32'h3; req0_unsigned = 1'b0;
    req1_b = 32'h10; req1_unsigned = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req1_a = 32'hE + 32'(k);
      @(negedge clk);
      n_cmp++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_grant[%0d]: ready0=%b ready1=%b, required 0 1", k, req0_ready, req1_ready);
      end
      n_cmp++;
      if (resp0_valid !== 1'b1 || resp0_result !== 32'h1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b result=%h, required 1 00000001", k, resp0_valid, resp0_result);
      end
      tick();
    end
    resp0_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_grant: req0_ready=%b, required 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++;
    if (resp0_valid !== 1'b1 || resp0_result !== 32'h0) begin
      n_fail++;
      $display("FAIL bp_reload: valid=%b result=%h, required 1 00000000", resp0_valid, resp0_result);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    send(0, 32'h2, 32'h1, 1'b0);
    send(1, 32'h2, 32'h3, 1'b0);
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h4; req0_b = 32'h8; req0_unsigned = 1'b1;
    req1_valid = 1'b1; req1_a = 32'h8; req1_b = 32'h4; req1_unsigned = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (resp0_valid !== 1'b1 || resp1_valid !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_pre: valid=%b/%b ready=%b/%b, required 1/1 0/0",
               resp0_valid, resp1_valid, req0_ready, req1_ready);
    end
    tick();
    reset = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    n_cmp++;
    if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_flush: valid=%b/%b, required 0/0", resp0_valid, resp1_valid);
    end
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_first: ready=%b/%b, required 1/0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_second: req1_ready=%b, required 1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_unsigned = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_unsigned = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0; reset = 1'b1;
    test_reset();
    test_port0_signed();
    test_port1_mixed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    n_cmp++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: outstanding=%0d/%0d, required 0/0", exp0_q.size(), exp1_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/slt_cmp_arbiter.md
Name: slt_cmp_arbiter

Overview:
Shares one set-less-than comparator between two requesters, port 0 and port 1. Typical requesters are the EX-stage SLT/SLTI path and the branch/compare unit. Each port has a valid/ready request channel and a valid/ready response channel. A round-robin arbiter grants at most one request per cycle, and the 0/1 result is registered into that port's response buffer.

Parameters:
DATA_WIDTH, 32, operand and result width
OPCODE_LENGTH, 4, reserved for opcode tagging; carried for consistency with the ALU family and unused inside the block

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous active-high reset
req0_valid  input  1  port 0 request valid
req0_ready  output  1  port 0 request accepted this cycle
req0_a  input  DATA_WIDTH  port 0 operand A (rs1)
req0_b  input  DATA_WIDTH  port 0 operand B (rs2 or sign-extended immediate)
req0_unsigned  input  1  0 = signed compare (SLT/SLTI), 1 = unsigned compare (SLTU/SLTIU)
resp0_valid  output  1  port 0 result valid
resp0_ready  input  1  port 0 consumer accepts result
resp0_result  output  DATA_WIDTH  port 0 result, 0x00000001 or 0x00000000
req1_valid, req1_ready, req1_a, req1_b, req1_unsigned  same as port 0, for port 1
resp1_valid, resp1_ready, resp1_result  same as port 0, for port 1

Behaviour:
- Clocking and reset:
  - Single clock domain; all state changes on the rising edge of clk.
  - reset is synchronous and active-high.
  - While reset is high: respN_valid=0, respN_result=0, last_grant=1 (port 0 wins the first contest), reqN_ready=0.
- Eligibility:
  - eligN = reqN_valid && (!respN_valid || respN_ready).
  - A port whose response buffer is full and not draining this cycle is never granted.
- Grant (combinational, single state bit last_grant):
  - elig0 && elig1: grant the port != last_grant.
  - Only one port eligible: grant that port.
  - Neither eligible: no grant.
  - reqN_ready = grantN. At most one ready is high per cycle.
- Handshake:
  - A request transfers when reqN_valid && reqN_ready.
  - Requester holds a, b and unsigned stable until ready.
  - Ready may depend combinationally on valid and on respN_ready.
- Compare:
  - unsigned=0: result = ($signed(a) < $signed(b)).
  - unsigned=1: result = (a < b).
  - Result is zero-extended to DATA_WIDTH.
  - Equal operands give 0. The most-negative value compared with the most-positive value gives 1 signed, 0 unsigned.
- Latency:
  - Result registered into respN_result and respN_valid=1 on the edge that accepts the request: 1-cycle latency.
  - Throughput is one compare per cycle in aggregate.
- Response buffer (per port, one entry):
  - respN_valid and respN_result hold until respN_valid && respN_ready.
  - Drain with no same-cycle grant: respN_valid clears.
  - Drain and a new grant to the same port in the same cycle: buffer reloads, respN_valid stays 1 (back-to-back).
- last_grant updates only on a grant. It is unchanged in idle cycles and in cycles where eligibility blocks the grant.
- Reset mid-operation:
  - Pending responses are discarded; valid drops the cycle after reset is sampled.
  - A request presented during reset is not accepted.
- Width: no overflow or saturation. The compare is the only arithmetic.

Test Plan:
- Port 0 only, signed, a=0x00000005, b=0x0000000A, resp0_ready=1 -> req0_ready=1 in cycle 0; resp0_valid=1 with resp0_result=0x00000001 in cycle 1.
- Port 0 signed, a=0x0000000F, b=0x0000000A -> result 0x00000000. Then a=b=0x0000000A -> result 0x00000000.
- Port 1, a=0xFFFFFFFB, b=0x00000003:
  - signed -> result 0x00000001.
  - Same operands unsigned -> result 0x00000000.
  - a=0x80000000, b=0x7FFFFFFF -> signed 1, unsigned 0.
- Both ports valid every cycle for 6 cycles, both resp_ready=1, starting after reset -> grant order 0,1,0,1,0,1. Each port gets 3 results matching its own operands; ready is never high on both ports in the same cycle.
- Backpressure:
  - Port 0 response held (resp0_ready=0) with req0 still valid -> req0_ready stays 0, port 1 is granted every cycle, resp0_result is stable.
  - Releasing resp0_ready -> drain and new grant in the same cycle, resp0_valid stays 1.
- Reset:
  - Assert reset for 1 cycle while resp0_valid=1 and resp1_valid=1 -> both valid are 0 after the edge.
  - Then simultaneous requests -> port 0 is granted first.
